// File: rtl/espectro_pkg.sv
// Shared types for the espectro note sequencer.
//   state_t : sequencer FSM states
//   note_t  : one note-table entry {fr, dur}
//   FR_REST / DUR_SKIP : special entry values (silent note / skipped entry)
package espectro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] fr;
    logic [15:0] dur;
  } note_t;

  localparam logic [31:0] FR_REST  = 32'd0;
  localparam logic [15:0] DUR_SKIP = 16'd0;

endpackage

// File: rtl/espectro_tick.sv
// Free-running TICK_DIV prescaler with synchronous restart.
//   clk, rst : clock, synchronous active-high reset (counter cleared to 0)
//   restart  : reload the counter so the next tick lands TICK_DIV cycles later
//   tick     : one-cycle pulse every TICK_DIV cycles
module espectro_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (restart || cnt == '0)   cnt <= RELOAD;
    else                             cnt <= cnt - 1'b1;
  end

  // Tick does not depend on restart, so the sequencer can restart the
  // prescaler in the same cycle it consumes the final tick of a note.
  assign tick = (cnt == '0);

endmodule

// File: rtl/espectro_seq.sv
// Note sequencer feeding the spectrum sound generator.
//   clk50, rst                        : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_fr/wr_dur        : note-table write port
//   start/len/loop                    : begin playback of len entries from 0
//   stop                              : abort to IDLE
//   fr/enable/init                    : generator divider, enable, new-note pulse
//   busy/note_idx/done                : status; done pulses on normal completion
module espectro_seq
  import espectro_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 1
) (
  input  logic          clk50,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_fr,
  input  logic [15:0]   wr_dur,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          loop,
  input  logic          stop,
  output logic [31:0]   fr,
  output logic          enable,
  output logic          init,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [15:0] GAP_L   = 16'(GAP_TICKS);

  note_t tbl [DEPTH];
  note_t cur;

  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          loop_q, loop_d;
  logic [15:0]   rem, rem_d;
  logic [31:0]   fr_d;
  logic          en_d, init_d, done_d;
  logic          restart, tick, advance, last;

  // Table is not reset; contents survive rst.
  always_ff @(posedge clk50) begin
    if (wr_en) tbl[wr_addr] <= {wr_fr, wr_dur};
  end

  assign cur = tbl[idx];

  espectro_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk50),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign last = ({1'b0, idx} == len_q - 1'b1);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    len_d   = len_q;
    loop_d  = loop_q;
    rem_d   = rem;
    fr_d    = fr;
    en_d    = enable;
    init_d  = 1'b0;
    done_d  = 1'b0;
    restart = 1'b0;
    advance = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop && len != '0) begin
          state_d = LOAD;
          idx_d   = '0;
          len_d   = (len > DEPTH_L) ? DEPTH_L : len;
          loop_d  = loop;
        end
      end
      LOAD: begin
        if (cur.dur == DUR_SKIP) begin
          advance = 1'b1;
        end else begin
          fr_d    = cur.fr;
          en_d    = (cur.fr != FR_REST);
          init_d  = 1'b1;
          rem_d   = cur.dur;
          restart = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (rem == 16'd1) begin
            en_d = 1'b0;
            if (GAP_TICKS != 0) begin
              state_d = GAP;
              rem_d   = GAP_L;
              restart = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end else begin
            rem_d = rem - 16'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (rem == 16'd1) advance = 1'b1;
          else              rem_d   = rem - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // End-of-entry rule shared by skip, gapless PLAY end and GAP end.
    if (advance) begin
      if (last && !loop_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
        fr_d    = '0;
        en_d    = 1'b0;
      end else begin
        state_d = LOAD;
        idx_d   = last ? '0 : idx + 1'b1;
      end
    end

    if (stop && state != IDLE) begin
      state_d = IDLE;
      fr_d    = '0;
      en_d    = 1'b0;
      init_d  = 1'b0;
      done_d  = 1'b0;
      restart = 1'b0;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      loop_q <= 1'b0;
      rem    <= '0;
      fr     <= '0;
      enable <= 1'b0;
      init   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      len_q  <= len_d;
      loop_q <= loop_d;
      rem    <= rem_d;
      fr     <= fr_d;
      enable <= en_d;
      init   <= init_d;
      done   <= done_d;
    end
  end

  assign busy     = (state != IDLE);
  assign note_idx = idx;

endmodule

// File: tb/tb_espectro_seq.sv
module tb_espectro_seq;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_fr = '0;
  logic [15:0] wr_dur = '0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        loop = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] fr;
  logic        enable, init, busy, done;
  logic [3:0]  note_idx;

  int n_run = 0;
  int n_fail = 0;

  int p_cyc, p_inits, p_en, p_i0;
  logic [31:0] p_fr0;

  espectro_seq #(.DEPTH(16), .AW(4), .TICK_DIV(10), .GAP_TICKS(1)) dut (
    .clk50(clk50), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fr(wr_fr),
    .wr_dur(wr_dur), .start(start), .len(len), .loop(loop), .stop(stop),
    .fr(fr), .enable(enable), .init(init), .busy(busy), .note_idx(note_idx),
    .done(done)
  );

  always #5 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk50);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] f, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_fr = f; wr_dur = d;
    step;
    wr_en = 1'b0;
  endtask

  // Issue start (cycle 0), then observe cycles 1.. until done or max.
  // p_cyc ends at the cycle where done is seen (or max).
  task automatic play(input logic [4:0] l, input logic lp, input int max);
    start = 1'b1; len = l; loop = lp;
    step;
    start = 1'b0;
    p_cyc = 1; p_inits = 0; p_en = 0; p_i0 = -1; p_fr0 = '1;
    while (!done && p_cyc < max) begin
      if (init) begin
        p_inits++;
        if (p_inits == 1) begin p_fr0 = fr; p_i0 = p_cyc; end
      end
      if (enable) p_en++;
      step;
      p_cyc++;
    end
  endtask

  initial begin
    int n;
    step; step;
    chk("rst_fr", fr, 0);
    chk("rst_en", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_init", init, 0);
    rst = 1'b0;
    step;

    // Reset in the middle of a note
    wr(0, 100, 3);
    start = 1'b1; len = 1; loop = 0;
    step;
    start = 1'b0;
    step; step; step; step;
    chk("mid_enable_before", enable, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_fr", fr, 0);
    chk("midrst_en", enable, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", note_idx, 0);
    step;

    // Single note after reset: table still holds {100,3}
    play(1, 0, 200);
    chk("single_init_cyc", p_i0, 2);
    chk("single_fr", p_fr0, 100);
    chk("single_inits", p_inits, 1);
    chk("single_en_cycles", p_en, 30);
    chk("single_done_cyc", p_cyc, 42);
    chk("single_done", done, 1);
    chk("single_busy_end", busy, 0);
    chk("single_fr_end", fr, 0);
    step;
    chk("single_done_pulse", done, 0);

    // Rest, skip, normal note
    wr(0, 0, 2);
    wr(1, 5, 0);
    wr(2, 7, 1);
    play(3, 0, 300);
    chk("rs_fr0", p_fr0, 0);
    chk("rs_inits", p_inits, 2);
    chk("rs_en_cycles", p_en, 10);
    chk("rs_done_cyc", p_cyc, 54);
    step;

    // Loop of two entries, then stop in second pass
    wr(0, 11, 1);
    wr(1, 22, 2);
    play(2, 1, 80);
    chk("loop_no_done", p_cyc, 80);
    chk("loop_inits", p_inits, 4);
    chk("loop_en_cycles", p_en, 45);
    chk("loop_idx", note_idx, 1);
    chk("loop_fr", fr, 22);
    stop = 1'b1;
    step;
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_en", enable, 0);
    chk("stop_fr", fr, 0);
    chk("stop_done", done, 0);
    step;
    chk("stop_done_later", done, 0);

    // Write to playing entry, start while busy
    start = 1'b1; len = 1; loop = 1;
    step;
    start = 1'b0;
    step;
    chk("wp_fr", fr, 11);
    chk("wp_init", init, 1);
    wr(0, 33, 1);
    step;
    chk("wp_fr_hold", fr, 11);
    chk("wp_en_hold", enable, 1);
    start = 1'b1; len = 3; loop = 0;
    step;
    start = 1'b0;
    n = 5;
    while (!init && n < 100) begin step; n++; end
    chk("wp_next_cyc", n, 23);
    chk("wp_new_fr", fr, 33);
    chk("wp_idx", note_idx, 0);
    stop = 1'b1;
    step;
    stop = 1'b0;
    chk("wp_stop_busy", busy, 0);

    // start+stop while idle
    start = 1'b1; stop = 1'b1; len = 1; loop = 0;
    step;
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    step;
    chk("ss_busy2", busy, 0);

    // len = 0
    start = 1'b1; len = 0;
    step;
    start = 1'b0;
    chk("len0_busy", busy, 0);
    step;
    chk("len0_done", done, 0);

    // len = 31 clamps to 16
    for (int i = 0; i < 16; i++) wr(4'(i), 32'(i + 1), 1);
    play(31, 0, 1000);
    chk("clamp_inits", p_inits, 16);
    chk("clamp_en_cycles", p_en, 160);
    chk("clamp_done_cyc", p_cyc, 337);
    chk("clamp_idx", note_idx, 15);
    chk("clamp_fr_end", fr, 0);
    step;
    chk("clamp_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/espectro_seq.md
Name: espectro_seq

Overview:
- Note sequencer that sits directly upstream of the spectrum sound generator.
- Holds a small table of (divider, duration) entries written by the J1/UART register interface.
- On command, steps through the table and drives the generator's divider value, enable and init inputs.
- Each note is held for a programmed number of millisecond ticks; an optional silent gap separates consecutive notes.

Parameters:
- DEPTH, 16: number of note entries, power of two.
- AW, 4: address width, log2(DEPTH).
- TICK_DIV, 50000: clk50 cycles per duration tick (1 ms at 50 MHz). Set to 10 in simulation.
- GAP_TICKS, 1: silent ticks inserted after each note. 0 means no gap.

Ports:
- clk50  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the note table.
- wr_addr  in  AW  table entry written.
- wr_fr  in  32  divider value for the entry; 0 means rest.
- wr_dur  in  16  duration in ticks; 0 means skip the entry.
- start  in  1  one-cycle command: begin playback at entry 0.
- len  in  AW+1  number of entries to play, sampled on start.
- loop  in  1  sampled on start; restart at entry 0 after the last entry.
- stop  in  1  one-cycle abort.
- fr  out  32  divider value to the generator.
- enable  out  1  generator enable.
- init  out  1  one-cycle pulse marking each newly presented note.
- busy  out  1  high whenever the state is not IDLE.
- note_idx  out  AW  index of the current entry.
- done  out  1  one-cycle pulse at normal (non-looping) completion.

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0. Table contents are NOT cleared.
- Reset has priority over every other input in the same cycle, including mid-note.
- Table writes:
  - Accepted in any state and take effect on the next cycle.
  - A write to the entry currently playing does not alter fr or the remaining duration. It is used on that entry's next load.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - start with len≠0: latch len and loop, set idx=0, go to LOAD.
  - start with len=0: ignored, no done pulse.
- LOAD (1 cycle): registered read of table[idx].
  - dur=0: skip. Advance idx, or finish via the end rule below; no init pulse.
  - Otherwise, next cycle:
    - fr ← entry fr; enable ← (entry fr≠0); init=1 for that one cycle.
    - Load the tick counter with TICK_DIV-1 and the remaining-ticks count with dur; go to PLAY.
- Latency: start at cycle N gives fr/enable/init valid at cycle N+2.
- PLAY:
  - Tick counter counts down each cycle. On reaching 0 it reloads and remaining is decremented.
  - When remaining reaches 0, the note has lasted exactly dur*TICK_DIV cycles.
  - Then: enable←0, fr holds its value. Go to GAP if GAP_TICKS≠0, else apply the end rule.
- GAP: enable=0 for GAP_TICKS*TICK_DIV cycles, then apply the end rule.
- End rule:
  - If idx=len-1: with loop set, idx←0 and go to LOAD; otherwise go to IDLE with done=1 for one cycle and fr←0.
  - Else idx←idx+1, go to LOAD.
- stop: in any non-IDLE state, next cycle is IDLE with enable=0, fr=0, and no done pulse.
- start while busy: ignored.
- start and stop in the same cycle: stop wins.
- len>DEPTH: clamped to DEPTH.
- Counter widths:
  - Tick counter: ceil(log2(TICK_DIV)) bits.
  - Remaining: 16 bits, so a maximum note of 65535 ticks with no overflow.
- busy=1 from the cycle after an accepted start until the IDLE return.

Decomposition:
- Package espectro_pkg holds:
  - the state enum (IDLE/LOAD/PLAY/GAP);
  - the note entry struct {fr[31:0], dur[15:0]};
  - localparams FR_REST=0 and DUR_SKIP=0.
- One sub-module, espectro_tick: a free-standing TICK_DIV prescaler with synchronous restart, emitting a 1-cycle tick.
- The note table is an inferred register array inside espectro_seq.

Test Plan:
- Reset mid-PLAY (TICK_DIV=10): assert rst for 1 cycle → next cycle fr=0, enable=0, busy=0. Table still reads back the old entries on the next start.
- Single note, entry0={fr=100, dur=3}, len=1, GAP_TICKS=1, start at cycle 0:
  - cycle 2: fr=100, enable=1, init=1;
  - enable stays high 30 cycles;
  - gap lasts 10 cycles;
  - then done pulses once and busy drops.
- Rest and skip, entries {fr=0,dur=2}, {fr=5,dur=0}, {fr=7,dur=1}, len=3:
  - enable=0 for 20 cycles during entry0;
  - entry1 produces no init pulse;
  - entry2 gives enable=1 with fr=7 for 10 cycles.
- Loop, len=2, loop=1: sequence repeats entry0, entry1, entry0, … with init once per note and no done. stop during the second pass → IDLE next cycle, no done.
- Simultaneous events:
  - start+stop while IDLE → stays IDLE;
  - start while busy → ignored;
  - a write to the currently playing entry changes nothing until the next loop iteration, which then plays the new fr.
- len=0 start → no state change, busy stays 0. len=31 with DEPTH=16 → plays 16 entries, then done.
